// File: rtl/actor_pkg.sv
// Shared types and constants for the actor movement/animation engine.
// Direction and state encodings are also what the renderer and debug probes see.
package actor_pkg;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    ATTACK = 2'd2
  } state_t;

  localparam logic [1:0] FR_IDLE   = 2'd0;
  localparam logic [1:0] FR_ATTACK = 2'd3;

  // Walk cycle 0,1,2,3 shows idle, walk1, idle, walk2.
  function automatic logic [1:0] frame_sel(input state_t s, input logic [1:0] walk);
    if (s == ATTACK) return FR_ATTACK;
    if (!walk[0]) return FR_IDLE;
    return 2'd1 + {1'b0, walk[1]};
  endfunction

endpackage

// File: rtl/actor_motion_if.sv
// Request/pixel bus between the game logic/renderer and the actor engine.
// All requests are plain levels with no valid/ready: the engine samples them only on a motion tick.
interface actor_motion_if #(
  parameter int ADDR_W = 13
);
  logic              move_up;
  logic              move_down;
  logic              move_left;
  logic              move_right;
  logic              attack_req;
  logic [8:0]        PixelX;
  logic [8:0]        PixelY;
  logic              is_obj;
  logic [ADDR_W-1:0] Obj_address;
  logic [8:0]        Obj_X_Pos;
  logic [8:0]        Obj_Y_Pos;
  logic [1:0]        Obj_Direction;
  logic              attacking;

  modport master (
    output move_up, move_down, move_left, move_right, attack_req, PixelX, PixelY,
    input  is_obj, Obj_address, Obj_X_Pos, Obj_Y_Pos, Obj_Direction, attacking
  );

  modport slave (
    input  move_up, move_down, move_left, move_right, attack_req, PixelX, PixelY,
    output is_obj, Obj_address, Obj_X_Pos, Obj_Y_Pos, Obj_Direction, attacking
  );
endinterface

// File: rtl/actor_tick_gen.sv
// Synchronises the vsync-rate frame_clk level, detects its rising edge and
// divides the edges by FRAME_DIV into a one-cycle motion tick.
module actor_tick_gen #(
  parameter int FRAME_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic o_tick
);
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  logic [CW-1:0] r_div;
  logic          r_tick;
  logic          w_pulse;
  logic          w_wrap;

  assign w_pulse = r_sync2 & ~r_sync3;
  assign w_wrap  = (r_div == CW'(FRAME_DIV - 1));
  assign o_tick  = r_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_div   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= w_pulse & w_wrap;
      if (w_pulse) r_div <= w_wrap ? '0 : r_div + 1'b1;
    end
  end
endmodule

// File: rtl/actor_motion.sv
// Actor movement, walk/attack animation and sprite-ROM addressing for the
// 320x240 playfield; position and FSM advance only on divided frame ticks.
module actor_motion
  import actor_pkg::*;
#(
  parameter int WIDTH          = 18,
  parameter int HEIGHT         = 20,
  parameter int X_MIN          = 1,
  parameter int X_MAX          = 319,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 239,
  parameter int START_X        = 151,
  parameter int START_Y        = 110,
  parameter int STEP           = 3,
  parameter int FRAME_DIV      = 4,
  parameter int ATTACK_TICKS   = 6,
  parameter int FRAMES_PER_DIR = 4,
  parameter int ADDR_W         = 13
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_clk,
  actor_motion_if.slave bus,
  output state_t       o_dbg_state
);
  localparam int AW = (ATTACK_TICKS > 1) ? $clog2(ATTACK_TICKS) : 1;
  localparam logic [AW-1:0] ATK_LOAD = AW'(ATTACK_TICKS - 1);
  localparam logic [9:0] X_HI   = 10'(X_MAX - WIDTH);
  localparam logic [9:0] X_LO   = 10'(X_MIN);
  localparam logic [9:0] Y_HI   = 10'(Y_MAX - HEIGHT);
  localparam logic [9:0] Y_LO   = 10'(Y_MIN);
  localparam logic [9:0] STEP10 = 10'(STEP);

  state_t        r_state;
  dir_t          r_dir;
  logic [8:0]    r_x;
  logic [8:0]    r_y;
  logic [1:0]    r_walk;
  logic [AW-1:0] r_atk;

  state_t        w_state_nx;
  dir_t          w_dir_nx;
  dir_t          w_dir_mv;
  logic [8:0]    w_x_nx;
  logic [8:0]    w_y_nx;
  logic [1:0]    w_walk_nx;
  logic [AW-1:0] w_atk_nx;
  logic          w_tick;
  logic          w_vx_pos, w_vx_neg, w_vy_pos, w_vy_neg, w_any;
  logic [9:0]    w_x_up, w_y_up;
  logic [8:0]    w_x_mv, w_y_mv;
  logic          w_attacking;
  logic [1:0]    w_frame;

  actor_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .o_tick    (w_tick)
  );

  // Opposing keys cancel per axis before anything else looks at them.
  assign w_vx_pos = bus.move_right & ~bus.move_left;
  assign w_vx_neg = bus.move_left  & ~bus.move_right;
  assign w_vy_pos = bus.move_down  & ~bus.move_up;
  assign w_vy_neg = bus.move_up    & ~bus.move_down;
  assign w_any    = w_vx_pos | w_vx_neg | w_vy_pos | w_vy_neg;

  // 10-bit sums/compares so stepping near 0 saturates instead of wrapping.
  assign w_x_up = {1'b0, r_x} + STEP10;
  assign w_y_up = {1'b0, r_y} + STEP10;

  always_comb begin
    w_x_mv = r_x;
    if (w_vx_pos)      w_x_mv = (w_x_up > X_HI) ? X_HI[8:0] : w_x_up[8:0];
    else if (w_vx_neg) w_x_mv = ({1'b0, r_x} < X_LO + STEP10) ? X_LO[8:0] : r_x - STEP10[8:0];
    w_y_mv = r_y;
    if (w_vy_pos)      w_y_mv = (w_y_up > Y_HI) ? Y_HI[8:0] : w_y_up[8:0];
    else if (w_vy_neg) w_y_mv = ({1'b0, r_y} < Y_LO + STEP10) ? Y_LO[8:0] : r_y - STEP10[8:0];
    if (w_vx_pos)      w_dir_mv = RIGHT;
    else if (w_vx_neg) w_dir_mv = LEFT;
    else if (w_vy_pos) w_dir_mv = DOWN;
    else               w_dir_mv = UP;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_dir   <= DOWN;
      r_x     <= 9'(START_X);
      r_y     <= 9'(START_Y);
      r_walk  <= '0;
      r_atk   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_dir   <= w_dir_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_walk  <= w_walk_nx;
      r_atk   <= w_atk_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_walk_nx  = r_walk;
    w_atk_nx   = r_atk;
    if (w_tick) begin
      case (r_state)
        IDLE, WALK: begin
          if (bus.attack_req) begin
            w_state_nx = ATTACK;
            w_atk_nx   = ATK_LOAD;
          end else if (w_any) begin
            w_state_nx = WALK;
            w_x_nx     = w_x_mv;
            w_y_nx     = w_y_mv;
            w_dir_nx   = w_dir_mv;
            w_walk_nx  = r_walk + 2'd1;
          end else if (r_state == WALK) begin
            w_state_nx = IDLE;
            w_walk_nx  = '0;
          end
        end
        ATTACK: begin
          if (r_atk == '0) w_state_nx = IDLE;
          else             w_atk_nx   = r_atk - 1'b1;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    w_attacking = (r_state == ATTACK);
    w_frame     = frame_sel(r_state, r_walk);
  end

  logic       w_in_x, w_in_y;
  logic [8:0] w_dx, w_dy;
  logic [ADDR_W-1:0] w_addr;

  assign w_in_x = (bus.PixelX >= r_x) && ({1'b0, bus.PixelX} < {1'b0, r_x} + 10'(WIDTH));
  assign w_in_y = (bus.PixelY >= r_y) && ({1'b0, bus.PixelY} < {1'b0, r_y} + 10'(HEIGHT));
  assign w_dx   = bus.PixelX - r_x;
  assign w_dy   = bus.PixelY - r_y;
  assign w_addr = ADDR_W'(w_dx) + ADDR_W'(w_dy) * ADDR_W'(WIDTH)
                + ADDR_W'(WIDTH * HEIGHT)
                  * (ADDR_W'(FRAMES_PER_DIR) * ADDR_W'(r_dir) + ADDR_W'(w_frame));

  assign bus.is_obj        = w_in_x & w_in_y;
  assign bus.Obj_address   = (w_in_x & w_in_y) ? w_addr : '0;
  assign bus.Obj_X_Pos     = r_x;
  assign bus.Obj_Y_Pos     = r_y;
  assign bus.Obj_Direction = r_dir;
  assign bus.attacking     = w_attacking;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_actor_motion.sv
// Bench for actor_motion: pixel/address vector table, hand-written motion,
// clamp, attack and reset sequences, then randomized ticks against a model.
module tb_actor_motion;
  import actor_pkg::*;

  localparam int FRAME_DIV = 4;
  localparam int ADDR_W    = 13;
  localparam int M_IDLE = 0, M_WALK = 1, M_ATK = 2;

  logic   clk = 1'b0;
  logic   reset;
  logic   frame_clk;
  state_t dbg_state;

  actor_motion_if #(.ADDR_W(ADDR_W)) bus ();

  actor_motion dut (
    .Clk         (clk),
    .Reset       (reset),
    .frame_clk   (frame_clk),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x, m_y, m_dir, m_st, m_walk, m_atk;

  task automatic model_reset();
    m_x = 151; m_y = 110; m_dir = 0; m_st = M_IDLE; m_walk = 0; m_atk = 0;
  endtask

  function automatic int ref_frame();
    if (m_st == M_ATK) return 3;
    if (m_walk % 2 == 0) return 0;
    return 1 + m_walk / 2;
  endfunction

  function automatic int ref_obj(input int px, input int py);
    return (px >= m_x && px < m_x + 18 && py >= m_y && py < m_y + 20) ? 1 : 0;
  endfunction

  function automatic int ref_addr(input int px, input int py);
    if (ref_obj(px, py) == 0) return 0;
    return (px - m_x) + (py - m_y) * 18 + 360 * (4 * m_dir + ref_frame());
  endfunction

  task automatic model_tick(input bit up, input bit dn, input bit lf, input bit rt, input bit atk);
    int vx, vy;
    vx = int'(rt) - int'(lf);
    vy = int'(dn) - int'(up);
    if (m_st == M_ATK) begin
      if (m_atk == 0) m_st = M_IDLE;
      else m_atk--;
    end else if (atk) begin
      m_st = M_ATK; m_atk = 5;
    end else if (vx != 0 || vy != 0) begin
      if (vx > 0) m_x = (m_x + 3 > 301) ? 301 : m_x + 3;
      if (vx < 0) m_x = (m_x - 3 < 1) ? 1 : m_x - 3;
      if (vy > 0) m_y = (m_y + 3 > 219) ? 219 : m_y + 3;
      if (vy < 0) m_y = (m_y - 3 < 0) ? 0 : m_y - 3;
      m_dir  = (vx > 0) ? 3 : (vx < 0) ? 1 : (vy > 0) ? 0 : 2;
      m_walk = (m_walk + 1) % 4;
      m_st   = M_WALK;
    end else if (m_st == M_WALK) begin
      m_st = M_IDLE; m_walk = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_keys(input bit up, input bit dn, input bit lf, input bit rt, input bit atk);
    bus.move_up = up; bus.move_down = dn; bus.move_left = lf;
    bus.move_right = rt; bus.attack_req = atk;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_tick(input bit up, input bit dn, input bit lf, input bit rt, input bit atk);
    set_keys(up, dn, lf, rt, atk);
    repeat (FRAME_DIV) frame_pulse();
    model_tick(up, dn, lf, rt, atk);
  endtask

  task automatic check_pix(input string tag, input int px, input int py);
    bus.PixelX = 9'(px);
    bus.PixelY = 9'(py);
    #1;
    check({tag, "_obj"}, int'(bus.is_obj), ref_obj(px, py));
    exp_q.push_back(ADDR_W'(ref_addr(px, py)));
    check({tag, "_addr"}, int'(bus.Obj_address), int'(exp_q.pop_front()));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"}, int'(bus.Obj_X_Pos), m_x);
    check({tag, "_y"}, int'(bus.Obj_Y_Pos), m_y);
    check({tag, "_dir"}, int'(bus.Obj_Direction), m_dir);
    check({tag, "_atk"}, int'(bus.attacking), (m_st == M_ATK) ? 1 : 0);
    check({tag, "_state"}, int'(dbg_state), m_st);
    check_pix(tag, m_x, m_y);
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int dir);
    check({tag, "_x"}, int'(bus.Obj_X_Pos), x);
    check({tag, "_y"}, int'(bus.Obj_Y_Pos), y);
    check({tag, "_dir"}, int'(bus.Obj_Direction), dir);
  endtask

  // ---------------- vector table (reset state: (151,110), dir 0, frame 0) ----------------
  typedef struct {
    int px;
    int py;
    int obj;
    int addr;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int wf[4];
    int wx[4];
    int px, py;

    vecs[0] = '{151, 110, 1, 0};
    vecs[1] = '{168, 110, 1, 17};
    vecs[2] = '{169, 110, 0, 0};
    vecs[3] = '{150, 110, 0, 0};
    vecs[4] = '{151, 129, 1, 342};
    vecs[5] = '{151, 130, 0, 0};
    vecs[6] = '{168, 129, 1, 359};
    vecs[7] = '{0, 0, 0, 0};
    wf = '{1, 0, 2, 0};
    wx = '{154, 157, 160, 163};

    reset = 1'b1;
    frame_clk = 1'b0;
    set_keys(0, 0, 0, 0, 0);
    bus.PixelX = 9'd0;
    bus.PixelY = 9'd0;
    repeat (3) @(negedge clk);
    check_pos("reset", 151, 110, 0);
    check("reset_atk", int'(bus.attacking), 0);
    check("reset_state", int'(dbg_state), M_IDLE);
    reset = 1'b0;
    model_reset();

    // Idle tick: nothing moves; then the pixel/address table.
    do_tick(0, 0, 0, 0, 0);
    check_model("idle");
    for (int i = 0; i < 8; i++) begin
      bus.PixelX = 9'(vecs[i].px);
      bus.PixelY = 9'(vecs[i].py);
      #1;
      check($sformatf("vec%0d_obj", i), int'(bus.is_obj), vecs[i].obj);
      check($sformatf("vec%0d_addr", i), int'(bus.Obj_address), vecs[i].addr);
    end

    // Walk right 4 ticks; the last tick is timed edge by edge.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        do_tick(0, 0, 0, 1, 0);
      end else begin
        set_keys(0, 0, 0, 1, 0);
        repeat (FRAME_DIV - 1) frame_pulse();
        frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_before_x", int'(bus.Obj_X_Pos), 160);
        @(posedge clk);
        @(negedge clk);
        check("lat_after_x", int'(bus.Obj_X_Pos), 163);
        frame_clk = 1'b0;
        repeat (3) @(negedge clk);
        model_tick(0, 0, 0, 1, 0);
      end
      check_pos($sformatf("walk%0d", k), wx[k], 110, 3);
      bus.PixelX = 9'(wx[k]);
      bus.PixelY = 9'd110;
      #1;
      check($sformatf("walk%0d_addr", k), int'(bus.Obj_address), 360 * (12 + wf[k]));
      check_model($sformatf("walkm%0d", k));
    end

    // Diagonal up+left toward the top-left corner; Y saturates from 2 to 0.
    repeat (36) do_tick(1, 0, 1, 0, 0);
    check_pos("diag36", 55, 2, 1);
    repeat (18) do_tick(0, 0, 1, 0, 0);
    check_pos("left18", 1, 2, 1);
    do_tick(1, 0, 1, 0, 0);
    check_pos("corner", 1, 0, 1);
    check_model("corner_m");
    do_tick(1, 0, 0, 0, 0);
    check_pos("top_hold", 1, 0, 2);

    // Attack while walking; attack_req held the whole time, no retrigger.
    do_tick(0, 0, 0, 1, 0);
    do_tick(0, 0, 0, 1, 0);
    check_pos("pre_atk", 7, 0, 3);
    for (int k = 0; k < 6; k++) begin
      do_tick(0, 0, 0, 1, 1);
      check($sformatf("atk%0d_on", k), int'(bus.attacking), 1);
      check_pos($sformatf("atk%0d", k), 7, 0, 3);
      bus.PixelX = 9'd7;
      bus.PixelY = 9'd0;
      #1;
      check($sformatf("atk%0d_addr", k), int'(bus.Obj_address), 5400);
    end
    do_tick(0, 0, 0, 0, 0);
    check("atk_end", int'(bus.attacking), 0);
    check("atk_end_state", int'(dbg_state), M_IDLE);
    check_model("atk_end_m");

    // Opposing keys cancel: no motion, direction held; leaving WALK clears the cycle.
    do_tick(0, 0, 1, 1, 0);
    check_pos("lr_idle", 7, 0, 3);
    do_tick(0, 0, 0, 1, 0);
    do_tick(0, 0, 1, 1, 0);
    check_pos("lr_walk", 10, 0, 3);
    check("lr_walk_state", int'(dbg_state), M_IDLE);
    bus.PixelX = 9'd10;
    bus.PixelY = 9'd0;
    #1;
    check("lr_walk_addr", int'(bus.Obj_address), 4320);

    // Reset mid-attack with a part-counted divider.
    do_tick(0, 0, 0, 0, 1);
    check("pre_rst_atk", int'(bus.attacking), 1);
    frame_pulse();
    frame_pulse();
    reset = 1'b1;
    @(negedge clk);
    check_pos("rst_mid", 151, 110, 0);
    check("rst_mid_atk", int'(bus.attacking), 0);
    check("rst_mid_state", int'(dbg_state), M_IDLE);
    reset = 1'b0;
    model_reset();
    set_keys(0, 0, 0, 1, 0);
    repeat (FRAME_DIV - 1) frame_pulse();
    check("div_restart_x", int'(bus.Obj_X_Pos), 151);
    frame_pulse();
    model_tick(0, 0, 0, 1, 0);
    check("div_tick_x", int'(bus.Obj_X_Pos), 154);

    // Randomized ticks against the model.
    for (int k = 0; k < 80; k++) begin
      do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0));
      check_model($sformatf("rnd%0d", k));
      px = m_x + int'($urandom_range(0, 19)) - 1;
      py = m_y + int'($urandom_range(0, 21)) - 1;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      check_pix($sformatf("rndpix%0d", k), px, py);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
